// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the BCD up/down counter.
// Digit width, digit ceiling and the digit clamp.
package bcd_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;

  function automatic bcd_digit_t bcd_clamp(
    input bcd_digit_t d
  );
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle between a counter and its driver.
// The driver owns controls; the counter owns q/tc/ovf.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 2
);

  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic                  ovf;

  modport master (
    output en,
    output up,
    output load,
    output load_val,
    input  q,
    input  tc,
    input  ovf
  );

  modport slave (
    input  en,
    input  up,
    input  load,
    input  load_val,
    output q,
    output tc,
    output ovf
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: next value and carry/borrow.
// Purely combinational; chained by the top level.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  bcd_digit_t d_in,
  input  logic       step,
  input  logic       up,
  output bcd_digit_t d_next,
  output logic       step_out
);

  always_comb begin
    d_next   = d_in;
    step_out = 1'b0;
    if (step) begin
      unique case (1'b1)
        (up && d_in == DIGIT_MAX): begin
          d_next   = '0;
          step_out = 1'b1;
        end
        (up && d_in != DIGIT_MAX): begin
          d_next = d_in + 4'd1;
        end
        (!up && d_in == '0): begin
          d_next   = DIGIT_MAX;
          step_out = 1'b1;
        end
        default: begin
          d_next = d_in - 4'd1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, wrap/saturate,
// combinational terminal count and registered overflow pulse.
module bcd_updown_counter
  import bcd_counter_pkg::*;
#(
  parameter int                  DIGITS    = 2,
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0,
  parameter bit                  SATURATE  = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  bcd_updown_counter_if.slave   bus
);

  localparam int W = DIGIT_W * DIGITS;

  function automatic logic [W-1:0] clamp_word(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[DIGIT_W*i +: DIGIT_W] =
        bcd_clamp(v[DIGIT_W*i +: DIGIT_W]);
    end
    return r;
  endfunction

  // A bad RESET_VAL digit is clamped too, so no
  // path can leave a non-BCD digit in the register.
  localparam logic [W-1:0] RST_Q = clamp_word(RESET_VAL);

  logic [W-1:0]  q_r;
  logic [W-1:0]  q_nxt;
  logic [DIGITS:0] step;
  logic          term;
  logic          ovf_r;

  assign step[0] = bus.en;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .d_in     (q_r[DIGIT_W*g +: DIGIT_W]),
      .step     (step[g]),
      .up       (bus.up),
      .d_next   (q_nxt[DIGIT_W*g +: DIGIT_W]),
      .step_out (step[g+1])
    );
  end

  // Carry out of the top digit means an enabled step
  // at all nines (up) or all zeros (down).
  assign term = step[DIGITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= RST_Q;
      ovf_r <= 1'b0;
    end else if (bus.load) begin
      q_r   <= clamp_word(bus.load_val);
      ovf_r <= 1'b0;
    end else if (bus.en) begin
      if (!(SATURATE && term)) begin
        q_r <= q_nxt;
      end
      ovf_r <= term;
    end else begin
      ovf_r <= 1'b0;
    end
  end

  assign bus.q   = q_r;
  assign bus.tc  = term;
  assign bus.ovf = ovf_r;

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with synchronous load, count enable, wrap or saturate mode, a terminal-count flag and a registered overflow pulse. It is the general form of the lab's fixed 4-bit up and down counters. It drives 7-segment and timer front-ends directly. Its `tc` output lets several instances be cascaded.

## Interface
- `DIGITS`, default 2: number of BCD digits. `q` is `4*DIGITS` bits wide. Allowed range is 1..8.
- `RESET_VAL`, default 0: value of `q` after reset, BCD-encoded in `4*DIGITS` bits. Every digit must be ≤ 9.
- `SATURATE`, default 0: 0 means the counter wraps at the terminal value. 1 means it holds at the terminal value.

Ports:
- `clk`  in  1  the single clock. All state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high. It has the highest priority.
- `en`  in  1  count enable. When low, `q` holds.
- `up`  in  1  count direction. 1 counts up, 0 counts down.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  `4*DIGITS`  BCD value written by `load`.
- `q`  out  `4*DIGITS`  current count, BCD. Digit 0 is in bits [3:0].
- `tc`  out  1  terminal count. Combinational.
- `ovf`  out  1  one-cycle registered overflow/underflow pulse.

## Operation
- Priority at each edge, highest first: `rst`, then `load`, then `en`, then hold.
- `rst` = 1: `q` ← `RESET_VAL`, `ovf` ← 0.
- `load` = 1: `q` ← `load_val`, `ovf` ← 0.
  - Any loaded digit greater than 9 is stored as 9. Other digits are unaffected.
  - `en` is ignored in a load cycle.
- `en` = 1 with `up` = 1: BCD increment.
  - A digit at 9 goes to 0 and carries into the next digit.
  - Terminal value is all nines.
- `en` = 1 with `up` = 0: BCD decrement.
  - A digit at 0 goes to 9 and borrows from the next digit.
  - Terminal value is all zeros.
- Count at terminal value with `SATURATE` = 0: wraps. All nines + 1 gives all zeros; all zeros − 1 gives all nines.
- Count at terminal value with `SATURATE` = 1: `q` holds.
- `ovf` ← 1 for exactly one cycle after any enabled count step taken at the terminal value, whether it wrapped or saturated. Otherwise `ovf` ← 0.
- `tc` = `en` & (`up` ? `q` == all nines : `q` == all zeros).
- The state never holds a non-BCD digit. No path may produce a digit of 10–15.

## Timing
- `q` and `ovf` are registers. Latency from `en`, `load` or `rst` to `q` is one edge.
- `tc` is combinational from `q`, `up` and `en`, with no register stage.
  - In a cascade, the upper instance's `en` is the lower instance's `tc`.
  - Both instances therefore step on the same edge.
- `ovf` rises on the same edge on which `q` wraps, or would have wrapped.
- A change of `up` while `en` is asserted takes effect on the next edge. There is no dead cycle.
- Reset mid-count, or in the same cycle as `load`, `en` or a terminal step: reset wins, and `ovf` is 0 on the following cycle.
- `load` in the same cycle as a terminal step: the load wins and `ovf` is 0.

## Structure
- Shared package `bcd_counter_pkg` holds:
  - `DIGIT_W` = 4 and `DIGIT_MAX` = 4'd9;
  - typedef `bcd_digit_t`;
  - function `bcd_clamp(bcd_digit_t)`, which returns min(d, 9).
- Sub-module `bcd_digit`, one instance per digit, purely combinational:
  - inputs: `d_in`, `step` (carry/borrow in), `up`;
  - outputs: `d_next`, `step_out` (carry/borrow out).
  - `step_out` is 1 when `step` is 1 and `d_in` equals 9 (up) or 0 (down).
- The top level chains `DIGITS` instances with a generate loop. Digit 0's `step` is `en`.
- The top level holds the single `q` register bank, the `ovf` register, the saturate mux and the load clamp.
- The final `step_out` qualifies the terminal condition.

## Test plan
All scenarios use `DIGITS` = 2 unless stated.
- Reset value: `RESET_VAL` = 8'h42, assert `rst` for 1 edge, then `en` = 0 for 3 edges → `q` = 42 throughout, `ovf` = 0, `tc` = 0.
- Up count across a digit and wrap: load 8'h97, `up` = 1, `en` = 1 → `q` = 98, 99, 00, 01. `tc` = 1 only while `q` = 99. `ovf` = 1 only in the cycle where `q` = 00.
- Down count across a digit and underflow, with saturate: `SATURATE` = 0, load 8'h01, `up` = 0 → `q` = 00, 99, 98, with `ovf` pulsing when `q` = 99. Repeat with `SATURATE` = 1 → `q` = 00, 00, 00, with an `ovf` pulse on each edge while `en` = 1.
- Load priority and clamping: `load` = 1, `en` = 1, `load_val` = 8'hC5, `q` = 99, `up` = 1 → `q` = 95 and `ovf` = 0.
- Reset priority: at `q` = 99, `up` = 1, assert `rst`, `load` and `en` together with `RESET_VAL` = 0 → `q` = 00 and `ovf` = 0.
- Cascade: two `DIGITS` = 1 instances, with the upper instance's `en` tied to the lower instance's `tc`, `up` = 1, 100 enabled edges from reset 0 → the concatenated value counts 00..99 and returns to 00 on edge 100, matching a `DIGITS` = 2 reference instance on every cycle.
